// File: rtl/pipe_demux_1_2_pkg.sv
// Shared types and defaults for the pipe_demux_1_2 stream demultiplexer.
// Holds the per-channel state encoding used by the skid stages and the top.
package pipe_demux_1_2_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } chanState_t;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_CNT_WIDTH = 16;

endpackage

// File: rtl/pipe_demux_1_2_skid_stage.sv
// Two-entry valid/ready register slice: a main register drives the output,
// a skid register catches the one word that arrives while the consumer stalls.
module pipe_skid_stage
    import pipe_demux_1_2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             outReady,
    output chanState_t       state,
    output logic             outValid,
    output logic [WIDTH-1:0] outData
);

    logic             pop;
    logic [WIDTH-1:0] skidData;

    assign pop = outValid && outReady;

    // Push is never asserted in FULL because the top drops in_ready for this channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            outValid <= 1'b0;
            outData  <= '0;
            skidData <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state    <= BUSY;
                        outValid <= 1'b1;
                        outData  <= pushData;
                    end
                end
                BUSY: begin
                    if (push && !pop) begin
                        state    <= FULL;
                        skidData <= pushData;
                    end else if (push && pop) begin
                        outData <= pushData;
                    end else if (pop) begin
                        state    <= EMPTY;
                        outValid <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state   <= BUSY;
                        outData <= skidData;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    outValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_demux_1_2.sv
// Registered 1-to-2 valid/ready stream demultiplexer with a skid stage per output.
// Define DEMUX_STATS_EN to add saturating per-channel push counters with a clear input.
module pipe_demux_1_2
    import pipe_demux_1_2_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH
`ifdef DEMUX_STATS_EN
   ,parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_STATS_EN
   ,input  logic                 stat_clr,
    output logic [CNT_WIDTH-1:0] stat_cnt0,
    output logic [CNT_WIDTH-1:0] stat_cnt1
`endif
);

    chanState_t state0;
    chanState_t state1;
    chanState_t selState;
    logic       push0;
    logic       push1;

    // Only the selected channel's fullness gates the input, so a stalled
    // destination never blocks words steered to the other one.
    assign selState = in_sel ? state1 : state0;
    assign in_ready = !rst && (selState != FULL);
    assign push0    = in_valid && in_ready && !in_sel;
    assign push1    = in_valid && in_ready &&  in_sel;

    pipe_skid_stage #(.WIDTH(WIDTH)) chan0 (
        .clk      (clk),
        .rst      (rst),
        .push     (push0),
        .pushData (in_data),
        .outReady (out0_ready),
        .state    (state0),
        .outValid (out0_valid),
        .outData  (out0_data)
    );

    pipe_skid_stage #(.WIDTH(WIDTH)) chan1 (
        .clk      (clk),
        .rst      (rst),
        .push     (push1),
        .pushData (in_data),
        .outReady (out1_ready),
        .state    (state1),
        .outValid (out1_valid),
        .outData  (out1_data)
    );

`ifdef DEMUX_STATS_EN
    // Clear wins over a coincident push; counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else if (stat_clr) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else begin
            if (push0 && (stat_cnt0 != '1)) begin
                stat_cnt0 <= stat_cnt0 + 1'b1;
            end
            if (push1 && (stat_cnt1 != '1)) begin
                stat_cnt1 <= stat_cnt1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_demux_1_2.sv
// Self-checking bench for pipe_demux_1_2: table-driven vectors plus directed
// sequences for streaming, mid-stream reset and (with DEMUX_STATS_EN) the counters.
module tb_pipe_demux_1_2;

    typedef struct {
        logic       inValid;
        logic       inSel;
        logic [7:0] inData;
        logic       r0;
        logic       r1;
        logic       expReady;
        logic       expV0;
        logic [7:0] expD0;
        logic       expV1;
        logic [7:0] expD1;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_sel;
    logic [7:0] in_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out0_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out1_data;
`ifdef DEMUX_STATS_EN
    logic       stat_clr;
    logic [3:0] stat_cnt0;
    logic [3:0] stat_cnt1;
`endif

    int assertCount = 0;
    int failCount   = 0;
    vec_t vecs[13];

`ifdef DEMUX_STATS_EN
    pipe_demux_1_2 #(.WIDTH(8), .CNT_WIDTH(4)) dut (
`else
    pipe_demux_1_2 #(.WIDTH(8)) dut (
`endif
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef DEMUX_STATS_EN
       ,.stat_clr   (stat_clr),
        .stat_cnt0  (stat_cnt0),
        .stat_cnt1  (stat_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_valid   = v.inValid;
        in_sel     = v.inSel;
        in_data    = v.inData;
        out0_ready = v.r0;
        out1_ready = v.r1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    initial begin
        // Alternating steering with both consumers ready, then channel-0 back-pressure.
        vecs[0]  = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h22};
        vecs[3]  = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h44};
        vecs[5]  = '{1'b1, 1'b0, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 1'b0, 8'hA2, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 1'b0, 8'hA3, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 8'h00};
        vecs[8]  = '{1'b1, 1'b1, 8'h5C, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 1'b0, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 8'h5C};
        vecs[10] = '{1'b1, 1'b0, 8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b1, 8'h5C};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};

        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef DEMUX_STATS_EN
        stat_clr = 1'b0;
`endif

        // Reset state
        @(negedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out0_valid", out0_valid, 0);
        checkOutput("rst_out1_valid", out1_valid, 0);
        checkOutput("rst_out0_data", out0_data, 0);
        checkOutput("rst_out1_data", out1_data, 0);
        rst = 1'b0;

        // Table-driven vectors: outputs reflect state before this cycle's edge
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].expReady);
            checkOutput($sformatf("vec%0d_out0_valid", i), out0_valid, vecs[i].expV0);
            checkOutput($sformatf("vec%0d_out1_valid", i), out1_valid, vecs[i].expV1);
            if (vecs[i].expV0) checkOutput($sformatf("vec%0d_out0_data", i), out0_data, vecs[i].expD0);
            if (vecs[i].expV1) checkOutput($sformatf("vec%0d_out1_data", i), out1_data, vecs[i].expD1);
        end

        // Continuous push and pop on channel 1: one word out every cycle
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i < 8) drive(1'b1, 1'b1, 8'(i), 1'b1, 1'b1);
            else       drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
            #1;
            if (i < 8) checkOutput($sformatf("stream%0d_in_ready", i), in_ready, 1);
            if (i > 0) begin
                checkOutput($sformatf("stream%0d_out1_valid", i), out1_valid, 1);
                checkOutput($sformatf("stream%0d_out1_data", i), out1_data, i - 1);
            end
        end

        // Fill both channels to FULL, then pulse reset between edges
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, i[1], 8'hC0 + 8'(i), 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
        #1;
        checkOutput("full_in_ready_sel0", in_ready, 0);
        checkOutput("full_out0_valid", out0_valid, 1);
        checkOutput("full_out0_data", out0_data, 8'hC0);
        in_sel = 1'b1;
        #1;
        checkOutput("full_in_ready_sel1", in_ready, 0);
        checkOutput("full_out1_data", out1_data, 8'hC2);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out0_valid", out0_valid, 0);
        checkOutput("midrst_out1_valid", out1_valid, 0);
        checkOutput("midrst_out0_data", out0_data, 0);
        checkOutput("midrst_out1_data", out1_data, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 8'h77, 1'b1, 1'b1);
        #1;
        checkOutput("postrst_in_ready", in_ready, 1);
        checkOutput("postrst_out0_valid", out0_valid, 0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        #1;
        checkOutput("postrst_out0_valid_next", out0_valid, 1);
        checkOutput("postrst_out0_data_next", out0_data, 8'h77);

`ifdef DEMUX_STATS_EN
        // Counters: clear, saturate on channel 0, then clear coinciding with a push
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        #1;
        checkOutput("stat_clr_cnt0", stat_cnt0, 0);
        checkOutput("stat_clr_cnt1", stat_cnt1, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 8'(i), 1'b1, 1'b1);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        #1;
        checkOutput("stat_sat_cnt0", stat_cnt0, 4'hF);
        checkOutput("stat_sat_cnt1", stat_cnt1, 0);
        drive(1'b1, 1'b0, 8'h99, 1'b1, 1'b1);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        #1;
        checkOutput("stat_clrpush_cnt0", stat_cnt0, 0);
        checkOutput("stat_clrpush_cnt1", stat_cnt1, 0);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pipe_demux_1_2.md
Name: pipe_demux_1_2

Overview:
- Registered 1-to-2 stream demultiplexer for the phase3 pipeline; the steering counterpart of the 2:1 select mux.
- Accepts one word per cycle on a valid/ready input and routes it, using a per-word select bit, to one of two valid/ready outputs.
- Each output has a 2-entry skid stage, so back-pressure on one destination never corrupts or drops data.
- Sits between a pipeline producer and two consumers, for example writeback versus store path.

Parameters:
- WIDTH, 8: data word width in bits.
- CNT_WIDTH, 16: width of the statistics counters (used only with DEMUX_STATS_EN).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_sel  in  1  destination select: 0 routes to out0, 1 routes to out1.
- in_data  in  WIDTH  input word.
- out0_valid  out  1  output 0 holds a word.
- out0_ready  in  1  consumer 0 takes the word.
- out0_data  out  WIDTH  output 0 word.
- out1_valid  out  1  output 1 holds a word.
- out1_ready  in  1  consumer 1 takes the word.
- out1_data  out  WIDTH  output 1 word.

Behaviour:
- Reset (asynchronous, active-high):
  - Both channels go EMPTY.
  - out0_valid=0, out1_valid=0, out0_data=0, out1_data=0.
  - in_ready=0 while rst is high.
  - Any word held at reset assertion is discarded.
- Per-channel state k in {0,1}: EMPTY, BUSY (main register valid), FULL (main and skid registers valid).
- Channel signals:
  - push_k = in_valid && in_ready && (in_sel==k).
  - pop_k = outk_valid && outk_ready.
- Transitions:
  - EMPTY: push goes to BUSY and loads main.
  - BUSY:
    - push && !pop goes to FULL; the word loads into skid.
    - push && pop stays BUSY; the new word loads into main.
    - !push && pop goes to EMPTY.
    - Otherwise hold.
  - FULL:
    - pop goes to BUSY; skid moves to main.
    - Push is impossible because ready=0.
- in_ready = !rst && (state[in_sel] != FULL). This is combinational from in_sel only; state is registered.
- outk_valid = (state_k != EMPTY). outk_data = main register. Both are registered outputs.
- Latency: 1 cycle from accept to outk_valid.
- Throughput: 1 word per cycle per channel while its consumer holds ready=1.
- Ordering: FIFO order preserved within a channel. No ordering relation between channels.
- outk_data is stable while outk_valid=1 and outk_ready=0.
- A blocked channel (FULL) stalls only words selected to it. in_ready still rises in the same cycle for words selected to the other channel.
- When in_valid=0, in_sel and in_data are don't-care.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined:
  - Adds outputs stat_cnt0 and stat_cnt1, each CNT_WIDTH bits.
  - Each counts pushes into its channel and saturates at all-ones with no wrap.
  - Reset clears both to 0.
  - Adds input stat_clr (1 bit), which synchronously zeroes both counters. If stat_clr coincides with a push, the counter is 0 after that cycle.
- Undefined: the stat ports and counters are absent. Data-path behaviour is identical.

Decomposition:
- Shared package:
  - Channel state encoding (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2).
  - Default WIDTH and CNT_WIDTH constants.
- Sub-module: pipe_skid_stage.
  - One 2-entry valid/ready register slice, instantiated twice.
  - The top level holds only the select decode and the in_ready mux.

Test Plan:
- Reset mid-stream, with both channels FULL and rst pulsed asynchronously between edges -> out0_valid=out1_valid=0 and data=0 immediately; in_ready=1 on the first cycle after release.
- Alternating sel 0,1,0,1 with data 0x11,0x22,0x33,0x44 and both readys=1 -> out0 delivers 0x11 then 0x33 and out1 delivers 0x22 then 0x44, each 1 cycle after accept; in_ready stays 1 throughout.
- out0_ready=0, pushing 0xA1, 0xA2, 0xA3 to channel 0 -> first two accepted, in_ready=0 for 0xA3; release ready -> 0xA1, 0xA2, 0xA3 in order with no loss.
- Channel 0 FULL and blocked, push 0x5C with sel=1 -> accepted the same cycle; out1_data=0x5C next cycle; channel 0 contents unchanged.
- Single channel with continuous push and pop (sel=1, out1_ready=1, 8 words 0x00..0x07) -> channel stays BUSY; 8 outputs on 8 consecutive cycles.
- DEMUX_STATS_EN with CNT_WIDTH=4 -> 20 pushes to channel 0 give stat_cnt0=0xF (saturated) and stat_cnt1=0; stat_clr -> both 0 next cycle.
